// File: rtl/nanomamba_pkg.sv
// Shared types and constants for the NanoMamba keyword-spotting decision stage.
package nanomamba_pkg;

  localparam int unsigned CLS_W     = 4;
  localparam int unsigned CONF_W    = 8;
  localparam int unsigned VOTE_W    = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned N_CLASSES = 12;

  localparam logic [CLS_W-1:0] SILENCE_CLASS = CLS_W'(0);
  localparam logic [CLS_W-1:0] UNKNOWN_CLASS = CLS_W'(1);

  typedef struct packed {
    logic             qual;
    logic [CLS_W-1:0] cls;
  } hist_entry_t;

  typedef enum logic [1:0] {
    S_ARMED = 2'd0,
    S_EVAL  = 2'd1,
    S_COOL  = 2'd2
  } state_t;

endpackage

// File: rtl/nanomamba_kws_decision_if.sv
// Classifier-result, host-interrupt and detection signals of the decision stage.
interface nanomamba_kws_decision_if;
  import nanomamba_pkg::*;

  logic                  cfg_enable;
  logic                  cls_valid;
  logic [CLS_W-1:0]      cls_index;
  logic [CONF_W-1:0]     cls_conf;
  logic                  irq_ack;
  logic                  det_valid;
  logic [CLS_W-1:0]      det_class;
  logic [VOTE_W-1:0]     det_votes;
  logic                  irq;
  logic                  overrun;
  logic [1:0]            state_o;

  modport master (
    output cfg_enable, cls_valid, cls_index, cls_conf, irq_ack,
    input  det_valid, det_class, det_votes, irq, overrun, state_o
  );

  modport slave (
    input  cfg_enable, cls_valid, cls_index, cls_conf, irq_ack,
    output det_valid, det_class, det_votes, irq, overrun, state_o
  );

endinterface

// File: rtl/nanomamba_vote_counter.sv
// Counts qualified history entries whose class matches the key class.
module nanomamba_vote_counter
  import nanomamba_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  hist_entry_t [DEPTH-1:0] hist,
  input  logic [CLS_W-1:0]        key,
  output logic [VOTE_W-1:0]       votes_c
);

  always_comb begin
    votes_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (hist[i].qual && (hist[i].cls == key)) begin
        votes_c = votes_c + VOTE_W'(1);
      end
    end
  end

endmodule

// File: rtl/nanomamba_kws_decision.sv
// Keyword decision: history of classifier results, majority vote, debounced
// detection with interrupt, overrun flag and post-detection cooldown.
module nanomamba_kws_decision
  import nanomamba_pkg::*;
#(
  parameter int unsigned HIST_DEPTH  = 4,
  parameter int unsigned VOTE_MIN    = 3,
  parameter int          CONF_THRESH = 32,
  parameter int unsigned COOLDOWN    = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  nanomamba_kws_decision_if.slave   bus
);

  localparam logic signed [CONF_W-1:0] CONF_THRESH_S = CONF_W'(CONF_THRESH);
  localparam logic [CLS_W-1:0]         N_CLASSES_L   = CLS_W'(N_CLASSES);
  localparam logic [VOTE_W-1:0]        VOTE_MIN_L    = VOTE_W'(VOTE_MIN);
  localparam logic [CNT_W-1:0]         COOLDOWN_L    = CNT_W'(COOLDOWN);

  state_t                       state_q;
  hist_entry_t [HIST_DEPTH-1:0] hist_q;
  logic [CNT_W-1:0]             cooldown_q;
  logic                         det_valid_q;
  logic [CLS_W-1:0]             det_class_q;
  logic [VOTE_W-1:0]            det_votes_q;
  logic                         irq_q;
  logic                         overrun_q;

  logic                         qual_c;
  hist_entry_t                  new_entry_c;
  logic [VOTE_W-1:0]            votes_c;

  // Entry qualifies on confidence and on being a real, in-range keyword class.
  assign qual_c = ($signed(bus.cls_conf) >= CONF_THRESH_S) &&
                  (bus.cls_index != SILENCE_CLASS) &&
                  (bus.cls_index != UNKNOWN_CLASS) &&
                  (bus.cls_index < N_CLASSES_L);

  assign new_entry_c.qual = qual_c;
  assign new_entry_c.cls  = bus.cls_index;

  nanomamba_vote_counter #(
    .DEPTH (HIST_DEPTH)
  ) u_vote (
    .hist    (hist_q),
    .key     (hist_q[0].cls),
    .votes_c (votes_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ARMED;
      hist_q      <= '0;
      cooldown_q  <= '0;
      det_valid_q <= 1'b0;
      det_class_q <= '0;
      det_votes_q <= '0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      det_valid_q <= 1'b0;
      // Acknowledge first so a same-cycle set below takes priority.
      if (bus.irq_ack) begin
        irq_q     <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (!bus.cfg_enable) begin
        state_q    <= S_ARMED;
        hist_q     <= '0;
        cooldown_q <= '0;
      end else begin
        case (state_q)
          S_ARMED: begin
            if (bus.cls_valid) begin
              hist_q  <= {hist_q[HIST_DEPTH-2:0], new_entry_c};
              state_q <= S_EVAL;
            end
          end
          S_EVAL: begin
            if (bus.cls_valid) begin
              overrun_q <= 1'b1;
            end
            if (hist_q[0].qual && (votes_c >= VOTE_MIN_L)) begin
              det_valid_q <= 1'b1;
              det_class_q <= hist_q[0].cls;
              det_votes_q <= votes_c;
              irq_q       <= 1'b1;
              hist_q      <= '0;
              cooldown_q  <= COOLDOWN_L;
              state_q     <= (COOLDOWN > 0) ? S_COOL : S_ARMED;
            end else begin
              state_q <= S_ARMED;
            end
          end
          S_COOL: begin
            // Results during cooldown are consumed without entering history.
            if (bus.cls_valid) begin
              if (cooldown_q <= CNT_W'(1)) begin
                cooldown_q <= '0;
                state_q    <= S_ARMED;
              end else begin
                cooldown_q <= cooldown_q - CNT_W'(1);
              end
            end
          end
          default: state_q <= S_ARMED;
        endcase
      end
    end
  end

  assign bus.det_valid = det_valid_q;
  assign bus.det_class = det_class_q;
  assign bus.det_votes = det_votes_q;
  assign bus.irq       = irq_q;
  assign bus.overrun   = overrun_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_nanomamba_kws_decision.sv
// Scoreboard bench for the keyword decision stage: stimulus pushes expected
// detections, a negedge monitor pops and compares them as det_valid appears.
module tb_nanomamba_kws_decision;
  import nanomamba_pkg::*;

  typedef struct {
    int cls;
    int votes;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];

  nanomamba_kws_decision_if bus ();

  nanomamba_kws_decision dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every detection must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && bus.det_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL det_unexpected: got class %0d votes %0d, expected no detection (cycle %0d)",
                 bus.det_class, bus.det_votes, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("det_class", int'(bus.det_class), e.cls);
        check("det_votes", int'(bus.det_votes), e.votes);
        check("det_latency_cycle", cyc, e.cyc);
        check("det_irq", int'(bus.irq), 1);
      end
    end
  end

  // One classifier result; if fire=1 the expected detection is queued.
  task automatic send(input int c, input int conf, input bit fire, input int votes, input int gap);
    exp_t e;
    @(posedge clk); #1;
    bus.cls_valid = 1'b1;
    bus.cls_index = CLS_W'(c);
    bus.cls_conf  = CONF_W'(conf);
    if (fire) begin
      e.cls = c; e.votes = votes; e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.cls_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Drop enable for one cycle, optionally acknowledging the interrupt too.
  task automatic clear_ctx(input bit ack);
    @(posedge clk); #1;
    bus.cfg_enable = 1'b0;
    bus.irq_ack    = ack;
    @(posedge clk); #1;
    bus.cfg_enable = 1'b1;
    bus.irq_ack    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_det_valid"}, int'(bus.det_valid), 0);
    check({tag, "_det_class"}, int'(bus.det_class), 0);
    check({tag, "_det_votes"}, int'(bus.det_votes), 0);
    check({tag, "_irq"},       int'(bus.irq), 0);
    check({tag, "_overrun"},   int'(bus.overrun), 0);
    check({tag, "_state"},     int'(bus.state_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n          = 1'b0;
    bus.cfg_enable = 1'b1;
    bus.cls_valid  = 1'b0;
    bus.cls_index  = '0;
    bus.cls_conf   = '0;
    bus.irq_ack    = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Three qualified (5,40), widely spaced: fires on the third.
    send(5, 40, 1'b0, 0, 100);
    send(5, 40, 1'b0, 0, 100);
    send(5, 40, 1'b1, 3, 100);
    check("t1_irq", int'(bus.irq), 1);
    check("t1_state_cool", int'(bus.state_o), 2);

    // Four results discarded by cooldown, then three more fire class 7.
    repeat (4) send(7, 100, 1'b0, 0, 3);
    check("t3_state_armed", int'(bus.state_o), 0);
    check("t3_det_class_held", int'(bus.det_class), 5);
    send(7, 100, 1'b0, 0, 3);
    send(7, 100, 1'b0, 0, 3);
    send(7, 100, 1'b1, 3, 3);
    check("t3_state_cool", int'(bus.state_o), 2);

    // Disable clears state; ack clears irq.
    clear_ctx(1'b1);
    check("clr_irq", int'(bus.irq), 0);
    check("clr_state", int'(bus.state_o), 0);
    check("clr_det_class_kept", int'(bus.det_class), 7);

    // Unqualified entry in the middle still occupies history.
    send(5, 40, 1'b0, 0, 3);
    send(5, 10, 1'b0, 0, 3);
    send(5, 40, 1'b0, 0, 3);
    send(5, 40, 1'b1, 3, 3);
    clear_ctx(1'b1);

    // Silence and unknown never detect.
    repeat (4) send(0, 127, 1'b0, 0, 3);
    repeat (4) send(1, 127, 1'b0, 0, 3);
    check("t4_irq", int'(bus.irq), 0);
    check("t4_state", int'(bus.state_o), 0);

    // Back-to-back results: second is dropped (overrun); ack lands with detection.
    send(5, 40, 1'b0, 0, 3);
    @(posedge clk); #1;
    bus.cls_valid = 1'b1; bus.cls_index = CLS_W'(5); bus.cls_conf = CONF_W'(40);
    @(posedge clk); #1;
    @(posedge clk); #1;
    begin
      exp_t e;
      e.cls = 5; e.votes = 3; e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.cls_valid = 1'b0;
    check("t5_overrun_set", int'(bus.overrun), 1);
    check("t5_irq_before", int'(bus.irq), 0);
    bus.irq_ack = 1'b1;
    @(posedge clk); #1;
    bus.irq_ack = 1'b0;
    check("t5_irq_set_wins", int'(bus.irq), 1);
    check("t5_overrun_cleared", int'(bus.overrun), 0);
    clear_ctx(1'b1);

    // Enable drop between results empties history: no detection.
    send(3, 50, 1'b0, 0, 3);
    send(3, 50, 1'b0, 0, 3);
    clear_ctx(1'b0);
    send(3, 50, 1'b0, 0, 3);
    send(3, 50, 1'b0, 0, 3);
    check("t6_irq", int'(bus.irq), 0);
    check("t6_det_class_kept", int'(bus.det_class), 5);

    // Async reset while evaluating a vote that would otherwise fire.
    @(posedge clk); #1;
    bus.cls_valid = 1'b1; bus.cls_index = CLS_W'(3); bus.cls_conf = CONF_W'(50);
    @(posedge clk); #1;
    bus.cls_valid = 1'b0;
    check("t6_state_eval", int'(bus.state_o), 1);
    rst_n = 1'b0;
    #2;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_state", int'(bus.state_o), 0);
    check("pending_expectations", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
